// File: rtl/ibex_rvfi_trace_buf_if.sv
// Retirement capture bus and trace word stream of the RVFI trace buffer.
interface ibex_rvfi_trace_buf_if #(
   parameter int unsigned Depth = 8
);
   logic                    trace_en_i;
   logic                    rvfi_valid_i;
   logic [63:0]             rvfi_order_i;
   logic [31:0]             rvfi_insn_i;
   logic [31:0]             rvfi_pc_rdata_i;
   logic                    rvfi_trap_i;
   logic                    rvfi_intr_i;
   logic                    rvfi_mem_is_cap_i;
   logic [4:0]              rvfi_rd_addr_i;
   logic [31:0]             rvfi_rd_wdata_i;
   logic [3:0]              rvfi_mem_rmask_i;
   logic [3:0]              rvfi_mem_wmask_i;
   logic                    trace_valid_o;
   logic                    trace_ready_i;
   logic [31:0]             trace_data_o;
   logic                    trace_last_o;
   logic [15:0]             drop_cnt_o;
   logic [$clog2(Depth):0]  fifo_level_o;

   // Trace buffer side.
   modport slave (
      input  trace_en_i, rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_pc_rdata_i,
      input  rvfi_trap_i, rvfi_intr_i, rvfi_mem_is_cap_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
      input  rvfi_mem_rmask_i, rvfi_mem_wmask_i, trace_ready_i,
      output trace_valid_o, trace_data_o, trace_last_o, drop_cnt_o, fifo_level_o
   );

   // Core / trace sink side.
   modport master (
      output trace_en_i, rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_pc_rdata_i,
      output rvfi_trap_i, rvfi_intr_i, rvfi_mem_is_cap_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
      output rvfi_mem_rmask_i, rvfi_mem_wmask_i, trace_ready_i,
      input  trace_valid_o, trace_data_o, trace_last_o, drop_cnt_o, fifo_level_o
   );
endinterface

// File: rtl/ibex_rvfi_trace_buf.sv
// RVFI retirement trace buffer: captures one record per retired instruction into a
// Depth-entry FIFO and serializes each record as four 32-bit words (hdr, pc, insn, wdata).
module ibex_rvfi_trace_buf #(
   parameter int unsigned Depth = 8
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   ibex_rvfi_trace_buf_if.slave   bus
);
   localparam int unsigned Aw     = $clog2(Depth);
   localparam int unsigned LevelW = Aw + 1;

   logic [31:0]       r_hdr   [Depth];
   logic [31:0]       r_pc    [Depth];
   logic [31:0]       r_insn  [Depth];
   logic [31:0]       r_wdata [Depth];
   logic [Aw-1:0]     r_wptr;
   logic [Aw-1:0]     r_rptr;
   logic [LevelW-1:0] r_level;
   logic [1:0]        r_widx;
   logic              r_pend;
   logic [15:0]       r_drop_cnt;

   logic              w_valid;
   logic              w_hs;
   logic              w_last;
   logic              w_pop;
   logic              w_full;
   logic              w_space;
   logic              w_req;
   logic              w_push;
   logic              w_drop;
   logic [31:0]       w_hdr;
   logic [31:0]       w_data;
   logic              w_unused_order;

   assign w_unused_order = ^bus.rvfi_order_i[63:21];

   assign w_valid = (r_level != '0);
   assign w_hs    = w_valid && bus.trace_ready_i;
   assign w_last  = w_valid && (r_widx == 2'd3);
   assign w_pop   = w_hs && w_last;
   assign w_full  = (r_level == LevelW'(Depth));
   // A full FIFO still has room if the head record leaves this very cycle.
   assign w_space = !w_full || w_pop;
   assign w_req   = bus.rvfi_valid_i && bus.trace_en_i;
   assign w_push  = w_req && w_space;
   assign w_drop  = w_req && !w_space;

   assign w_hdr = {r_pend, bus.rvfi_trap_i, bus.rvfi_intr_i, bus.rvfi_mem_is_cap_i,
                   |bus.rvfi_mem_rmask_i, |bus.rvfi_mem_wmask_i, bus.rvfi_rd_addr_i,
                   bus.rvfi_order_i[20:0]};

   // Select the current word of the head record; zero when nothing is stored.
   always_comb begin
      w_data = '0;
      if (w_valid) begin
         unique case (r_widx)
            2'd0: w_data = r_hdr[r_rptr];
            2'd1: w_data = r_pc[r_rptr];
            2'd2: w_data = r_insn[r_rptr];
            default: w_data = r_wdata[r_rptr];
         endcase
      end
   end

   assign bus.trace_valid_o = w_valid;
   assign bus.trace_data_o  = w_data;
   assign bus.trace_last_o  = w_last;
   assign bus.drop_cnt_o    = r_drop_cnt;
   assign bus.fifo_level_o  = r_level;

   // Record storage; contents are don't-care until a push, so no reset.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_hdr[r_wptr]   <= w_hdr;
         r_pc[r_wptr]    <= bus.rvfi_pc_rdata_i;
         r_insn[r_wptr]  <= bus.rvfi_insn_i;
         r_wdata[r_wptr] <= bus.rvfi_rd_wdata_i;
      end
   end

   // Pointers, occupancy and serializer word index.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_widx  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + Aw'(1);
         if (w_pop)  r_rptr <= r_rptr + Aw'(1);
         if (w_hs)   r_widx <= r_widx + 2'd1;
         if (w_push && !w_pop) begin
            r_level <= r_level + LevelW'(1);
         end else if (w_pop && !w_push) begin
            r_level <= r_level - LevelW'(1);
         end
      end
   end

   // Overflow accounting: saturating drop counter and sticky flag for the next header.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pend     <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_drop) begin
            r_pend <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
         end else if (w_push) begin
            r_pend <= 1'b0;
         end
      end
   end
endmodule
